// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
// Mode encodings and the stage-0 carry-in selection live here.
package pipe_adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Subtraction is A + ~B + 1, so the external carry-in is ignored then.
  function automatic logic first_cin(input logic mode, input logic cin);
    return (mode == MODE_SUB) ? 1'b1 : cin;
  endfunction

endpackage

// File: rtl/pipe_adder_fa_seg.sv
// 1-bit full-adder cell and the SEG-bit ripple segment built from it.
// Cmsb exposes the carry into the segment's top bit for overflow detection.
module fa (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

module fa_seg
  import pipe_adder_pkg::*;
#(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] A,
  input  logic [SEG-1:0] B,
  input  logic           Cin,
  output logic [SEG-1:0] Sum,
  output logic           Cout,
  output logic           Cmsb
);

  // Each bit keeps its own carry nets so the chain is not one self-dependent vector.
  for (genvar i = 0; i < SEG; i++) begin : g_bit
    logic ci;
    logic co;
    if (i == 0) begin : g_first
      assign ci = Cin;
    end else begin : g_rest
      assign ci = g_bit[i-1].co;
    end
    fa u_fa (
      .A    (A[i]),
      .B    (B[i]),
      .Cin  (ci),
      .Sum  (Sum[i]),
      .Cout (co)
    );
  end

  assign Cout = g_bit[SEG-1].co;
  assign Cmsb = g_bit[SEG-1].ci;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined ripple-carry add/subtract unit with valid/ready flow control.
// Stage k resolves bits [k*SEG +: SEG] and hands its carry to stage k+1.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int PEND = (STAGES > 1) ? STAGES - 1 : 1;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipe_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] src_vld;
  logic [STAGES:0]   ld;
  logic [WIDTH-1:0]  s_q [STAGES];
  logic              c_q [STAGES];
  logic [WIDTH-1:0]  a_q [PEND];
  logic [WIDTH-1:0]  b_q [PEND];
  logic              cmsb_q;

  logic [WIDTH-1:0]  b_in;
  logic [SEG-1:0]    seg_a  [STAGES];
  logic [SEG-1:0]    seg_b  [STAGES];
  logic [SEG-1:0]    seg_s  [STAGES];
  logic              seg_ci [STAGES];
  logic              seg_co [STAGES];
  logic              seg_cm [STAGES];
  logic [WIDTH-1:0]  s_nx   [STAGES];
  logic [WIDTH-1:0]  a_nx   [PEND];
  logic [WIDTH-1:0]  b_nx   [PEND];

  assign b_in    = (Mode == MODE_SUB) ? ~B : B;
  assign src_vld = STAGES'({vld, in_valid});

  // A stage may load when it is empty or its occupant moves on this cycle.
  always_comb begin
    ld         = '0;
    ld[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ld[k] = !vld[k] || ld[k+1];
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      seg_a[k]  = '0;
      seg_b[k]  = '0;
      seg_ci[k] = 1'b0;
    end
    seg_a[0]  = A[SEG-1:0];
    seg_b[0]  = b_in[SEG-1:0];
    seg_ci[0] = first_cin(Mode, Cin);
    for (int k = 1; k < STAGES; k++) begin
      seg_a[k]  = a_q[k-1][SEG-1:0];
      seg_b[k]  = b_q[k-1][SEG-1:0];
      seg_ci[k] = c_q[k-1];
    end
  end

  // Pending operand bits are kept right-aligned so every stage reads its low SEG bits.
  always_comb begin
    for (int k = 0; k < PEND; k++) begin
      a_nx[k] = '0;
      b_nx[k] = '0;
    end
    a_nx[0] = A >> SEG;
    b_nx[0] = b_in >> SEG;
    for (int k = 1; k < STAGES - 1; k++) begin
      a_nx[k] = a_q[k-1] >> SEG;
      b_nx[k] = b_q[k-1] >> SEG;
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      s_nx[k] = '0;
    end
    s_nx[0] = WIDTH'(seg_s[0]);
    for (int k = 1; k < STAGES; k++) begin
      s_nx[k] = s_q[k-1] | (WIDTH'(seg_s[k]) << (k * SEG));
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    fa_seg #(.SEG(SEG)) u_seg (
      .A    (seg_a[k]),
      .B    (seg_b[k]),
      .Cin  (seg_ci[k]),
      .Sum  (seg_s[k]),
      .Cout (seg_co[k]),
      .Cmsb (seg_cm[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld    <= '0;
      cmsb_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
      for (int k = 0; k < PEND; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) begin
          vld[k] <= src_vld[k];
          if (src_vld[k]) begin
            s_q[k] <= s_nx[k];
            c_q[k] <= seg_co[k];
          end
        end
      end
      for (int k = 0; k < PEND; k++) begin
        if (ld[k] && src_vld[k]) begin
          a_q[k] <= a_nx[k];
          b_q[k] <= b_nx[k];
        end
      end
      if (ld[STAGES-1] && src_vld[STAGES-1]) begin
        cmsb_q <= seg_cm[STAGES-1];
      end
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = vld[STAGES-1];
  assign Sum       = s_q[STAGES-1];
  assign Cout      = c_q[STAGES-1];
  assign Ovf       = cmsb_q ^ c_q[STAGES-1];

endmodule
